// File: rtl/dda_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dda_move_sequencer
//  Purpose  : Move-level controller for the DDA step timer. Buffers up to two
//             move descriptors, sequences LOAD/EXEC strobes to the timer and
//             ends each move after its duration in dda_tick rising edges.
//  Revision : 1.0  initial release
//
//  Ports
//    CLK, resetn                 clock, synchronous active-low reset
//    move_valid / move_ready     descriptor handshake into the 2-slot buffer
//    move_duration               move length in dda_tick rising edges
//    move_increment              initial increment for the timer
//    move_incrementincrement     per-tick increment delta for the timer
//    move_dir                    step direction
//    abort                       flush buffer and stop motion immediately
//    dda_tick                    raw DDA tick (same signal as the timer's)
//    increment, incrementincrement, dir
//                                head-slot fields, held when buffer empty
//    loading_move                one-cycle load strobe to the timer
//    executing_move              high while the active move is running
//    move_done                   one-cycle pulse per completed move
//    busy                        FSM active or buffer non-empty
//    moves_completed             (DDA_MOVE_SEQ_COUNT_EN only) wrapping count
//                                of move_done pulses
//
//  Build option: define DDA_MOVE_SEQ_COUNT_EN to add moves_completed.
// ============================================================================
module dda_move_sequencer #(
  parameter int DDA_BITS = 64,
  parameter int DUR_BITS = 32
) (
  input  logic                CLK,
  input  logic                resetn,
  input  logic                move_valid,
  output logic                move_ready,
  input  logic [DUR_BITS-1:0] move_duration,
  input  logic [DDA_BITS-1:0] move_increment,
  input  logic [DDA_BITS-1:0] move_incrementincrement,
  input  logic                move_dir,
  input  logic                abort,
  input  logic                dda_tick,
  output logic [DDA_BITS-1:0] increment,
  output logic [DDA_BITS-1:0] incrementincrement,
  output logic                dir,
  output logic                loading_move,
  output logic                executing_move,
  output logic                move_done,
`ifdef DDA_MOVE_SEQ_COUNT_EN
  output logic [31:0]         moves_completed,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Descriptor buffer
  logic [DUR_BITS-1:0] r_slot_dur    [2];
  logic [DDA_BITS-1:0] r_slot_inc    [2];
  logic [DDA_BITS-1:0] r_slot_incinc [2];
  logic                r_slot_dir    [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  // Last head fields, presented while the buffer is empty
  logic [DDA_BITS-1:0] r_hold_inc;
  logic [DDA_BITS-1:0] r_hold_incinc;
  logic                r_hold_dir;

  logic                r_tick_d;
  logic [DUR_BITS-1:0] r_ticks;
  logic                r_done;

  logic                w_tick_edge;
  logic                w_push;
  logic                w_pop;
  logic                w_done_set;
  logic                w_ticks_clr;
  logic                w_ticks_inc;
  logic                w_more;
  logic [DUR_BITS-1:0] w_head_dur;
  logic [DUR_BITS-1:0] w_ticks_plus1;

  // Same single-register detector as the timer, so both see an edge in the
  // same cycle.
  assign w_tick_edge   = dda_tick & ~r_tick_d;

  assign move_ready    = (r_count != 2'd2);
  // A push offered in the abort cycle is dropped along with the buffer.
  assign w_push        = move_valid & move_ready & ~abort;
  assign w_head_dur    = r_slot_dur[r_rd_ptr];
  assign w_ticks_plus1 = r_ticks + {{(DUR_BITS-1){1'b0}}, 1'b1};
  // Another move remains after the current pop (counting a same-cycle push).
  assign w_more        = (r_count == 2'd2) | w_push;

  assign increment          = (r_count != 2'd0) ? r_slot_inc[r_rd_ptr]    : r_hold_inc;
  assign incrementincrement = (r_count != 2'd0) ? r_slot_incinc[r_rd_ptr] : r_hold_incinc;
  assign dir                = (r_count != 2'd0) ? r_slot_dir[r_rd_ptr]    : r_hold_dir;

  assign move_done = r_done;
  assign busy      = (r_state != ST_IDLE) | (r_count != 2'd0);

  // Next-state and strobe logic
  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_done_set     = 1'b0;
    w_ticks_clr    = 1'b0;
    w_ticks_inc    = 1'b0;
    loading_move   = 1'b0;
    executing_move = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != 2'd0) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        loading_move = 1'b1;
        w_ticks_clr  = 1'b1;
        if (w_head_dur == '0) begin
          w_pop        = 1'b1;
          w_done_set   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        executing_move = 1'b1;
        if (w_tick_edge) begin
          if (w_ticks_plus1 == w_head_dur) begin
            w_pop        = 1'b1;
            w_done_set   = 1'b1;
            w_state_next = w_more ? ST_LOAD : ST_IDLE;
          end else begin
            w_ticks_inc = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Abort overrides everything, including a coincident final edge.
    if (abort) begin
      w_state_next = ST_IDLE;
      w_pop        = 1'b0;
      w_done_set   = 1'b0;
      w_ticks_inc  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_hold_inc    <= '0;
      r_hold_incinc <= '0;
      r_hold_dir    <= 1'b0;
      r_tick_d      <= 1'b0;
      r_ticks       <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_tick_d <= dda_tick;
      r_done   <= w_done_set;
      if (r_count != 2'd0) begin
        r_hold_inc    <= r_slot_inc[r_rd_ptr];
        r_hold_incinc <= r_slot_incinc[r_rd_ptr];
        r_hold_dir    <= r_slot_dir[r_rd_ptr];
      end
      if (abort) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
      if (w_ticks_clr)      r_ticks <= '0;
      else if (w_ticks_inc) r_ticks <= w_ticks_plus1;
    end
  end

  // Slot storage needs no reset: it is only observed while r_count != 0.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_slot_dur[r_wr_ptr]    <= move_duration;
      r_slot_inc[r_wr_ptr]    <= move_increment;
      r_slot_incinc[r_wr_ptr] <= move_incrementincrement;
      r_slot_dir[r_wr_ptr]    <= move_dir;
    end
  end

`ifdef DDA_MOVE_SEQ_COUNT_EN
  logic [31:0] r_moves_completed;

  always_ff @(posedge CLK) begin
    if (!resetn) r_moves_completed <= 32'd0;
    else if (r_done) r_moves_completed <= r_moves_completed + 32'd1;
  end

  assign moves_completed = r_moves_completed;
`endif

endmodule
`default_nettype wire
